sdram_pll_lock_monitor: RTL

Reset sequencer and lock supervisor sitting on the other side of the SDRAM PLL's `rst`/`locked` interface. It pulses the PLL reset, waits for lock with a timeout, and qualifies lock stability before releasing the SDRAM controller reset. On loss of lock it re-asserts the downstream reset and retries. It runs on the 50 MHz board reference clock that also feeds the PLL, so it never depends on the clocks it supervises.

---
 rtl/sdram_pll_lock_monitor_if.sv | 30 +++
 rtl/sdram_pll_lock_monitor.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sdram_pll_lock_monitor_if.sv
// PLL-side and SDRAM-side signal bundle for sdram_pll_lock_monitor.
// master = the monitor, slave = the PLL / SDRAM controller side.
interface sdram_pll_lock_monitor_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst_n;
  logic             ready;
  logic             timeout_err;
  logic [CNT_W-1:0] relock_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rst_n,
    output ready,
    output timeout_err,
    output relock_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rst_n,
    input  ready,
    input  timeout_err,
    input  relock_count
  );
endinterface

// File: rtl/sdram_pll_lock_monitor.sv
// SDRAM PLL reset sequencer / lock supervisor on the board reference clock.
// Optional feature macro: SDRAM_PLL_RELOCK_CNT_EN builds the saturating relock counter.
module sdram_pll_lock_monitor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  sdram_pll_lock_monitor_if.master     io_pll
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CYC_W   = $clog2(MAX_CYC);

  localparam logic [CYC_W-1:0] RST_LAST    = CYC_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CYC_W-1:0] STABLE_LAST = CYC_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST    = CYC_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE_CHK,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CYC_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_locked_s;
  logic             r_pll_rst;
  logic             r_sys_rst_n;
  logic             r_ready;
  logic             r_timeout_err;
  logic             w_timeout;
  logic [CNT_W-1:0] w_relock_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 1'b0;
      r_locked_s <= 1'b0;
    end else begin
      r_sync1    <= io_pll.pll_locked;
      r_locked_s <= r_sync1;
    end
  end

  // Lock arriving on the timeout terminal count wins over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    unique case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == RST_LAST) w_next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (r_locked_s) begin
          w_next_state = S_STABLE_CHK;
        end else if (r_cnt == TMO_LAST) begin
          w_next_state = S_RESET_PLL;
          w_timeout    = 1'b1;
        end
      end
      S_STABLE_CHK: begin
        if (!r_locked_s)                w_next_state = S_WAIT_LOCK;
        else if (r_cnt == STABLE_LAST)  w_next_state = S_RUN;
      end
      S_RUN: begin
        if (!r_locked_s) w_next_state = S_RESET_PLL;
      end
      default: w_next_state = S_RESET_PLL;
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RESET_PLL;
      r_cnt         <= '0;
      r_pll_rst     <= 1'b1;
      r_sys_rst_n   <= 1'b0;
      r_ready       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) r_cnt <= '0;
      else if (r_cnt != '1)        r_cnt <= r_cnt + 1'b1;
      r_pll_rst     <= (w_next_state == S_RESET_PLL);
      r_sys_rst_n   <= (w_next_state == S_RUN);
      r_ready       <= (w_next_state == S_RUN);
      r_timeout_err <= r_timeout_err | w_timeout;
    end
  end

`ifdef SDRAM_PLL_RELOCK_CNT_EN
  logic [CNT_W-1:0] r_relock_count;
  logic             w_lock_lost;

  assign w_lock_lost = (r_state == S_RUN) && !r_locked_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_relock_count <= '0;
    else if (w_lock_lost && r_relock_count != '1) r_relock_count <= r_relock_count + 1'b1;
  end

  assign w_relock_count = r_relock_count;
`else
  assign w_relock_count = '0;
`endif

  assign io_pll.pll_rst      = r_pll_rst;
  assign io_pll.sys_rst_n    = r_sys_rst_n;
  assign io_pll.ready        = r_ready;
  assign io_pll.timeout_err  = r_timeout_err;
  assign io_pll.relock_count = w_relock_count;

endmodule
